// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit scan encoder: FSM state encoding and index-width derivation.
package bit_scan_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Index width for an n-bit vector; never below one bit so tiny vectors still have a y port.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_index.sv
// Combinational priority encoder: vector -> index of the winning set bit plus an any flag.
// Priority is the lowest set bit by default, the highest when BIT_SCAN_MSB_FIRST_EN is defined.
module prio_index
    import bit_scan_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]               v,
    output logic [clog2_safe(N)-1:0]   idx,
    output logic                       any
);

    localparam int W = clog2_safe(N);

    always_comb begin
        idx = '0;
        any = |v;
`ifdef BIT_SCAN_MSB_FIRST_EN
        // Ascending walk: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
`else
        // Descending walk: the last hit, i.e. the lowest set bit, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/bit_scan_encoder.sv
// Sequential multi-hot to index encoder: accepts a vector, then emits one beat per set bit.
// Scan order is LSB first by default, MSB first when BIT_SCAN_MSB_FIRST_EN is defined.
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [clog2_safe(N)-1:0]   y,
    output logic                       out_last,
    output logic                       out_zero
);

    localparam int W = clog2_safe(N);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until then, ready never depends on same-side valid.

    state_e         state_q, state_d;
    logic [N-1:0]   hv_q, hv_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   cur_idx;
    logic           cur_any;
    logic           single_bit;
    logic           last_beat;

    prio_index #(.N(N)) u_prio_index (
        .v   (hv_q),
        .idx (cur_idx),
        .any (cur_any)
    );

    assign single_bit = cur_any && ((hv_q & (hv_q - N'(1))) == '0);
    assign last_beat  = zero_q || single_bit;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_SCAN);
    assign y         = out_valid ? cur_idx : '0;
    assign out_last  = out_valid && last_beat;
    assign out_zero  = out_valid && zero_q;

    always_comb begin
        state_d = state_q;
        hv_d    = hv_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SCAN;
                    hv_d    = d;
                    zero_d  = (d == '0);
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    for (int i = 0; i < N; i++) begin
                        if (cur_idx == W'(i)) begin
                            hv_d[i] = 1'b0;
                        end
                    end
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        zero_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hv_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hv_q    <= hv_d;
            zero_q  <= zero_d;
        end
    end

endmodule
